// File: rtl/lane_renderer_pkg.sv
// lane_renderer_pkg: colour and active-area constants shared by the lane renderer
package lane_renderer_pkg;
  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [7:0] C_BLANK     = 8'h00;
  localparam logic [7:0] C_FROG      = 8'h1C;
  localparam logic [7:0] C_OBJ       = 8'hE0;
  localparam logic [7:0] C_LANE_EVEN = 8'h49;
  localparam logic [7:0] C_LANE_ODD  = 8'h24;
  localparam logic [7:0] C_GRASS     = 8'h10;
endpackage

// File: rtl/lane_scroller.sv
// lane_scroller: one lane's scroll offset plus its row-range and object-phase compare
module lane_scroller #(
  parameter int PER_LOG2 = 7,
  parameter int OBJ_LEN  = 48,
  parameter int Y_LO     = 112,
  parameter int Y_HI     = 144
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       step,
  input  logic [2:0] speed,
  input  logic       dir,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  output logic       in_lane,
  output logic       is_obj
);
  logic [PER_LOG2-1:0] offset_q, offset_d, phase;
  // advance the offset once per frame, phase wraps naturally at the period width
  always_comb begin
    offset_d = step ? offset_q + PER_LOG2'(speed) : offset_q;
    phase    = PER_LOG2'(dir ? next_x + 10'(offset_q) : next_x - 10'(offset_q));
    in_lane  = 32'(next_y) >= Y_LO && 32'(next_y) < Y_HI;
    is_obj   = in_lane && 32'(phase) < OBJ_LEN;
  end
  // offset register, reset wins over any frame step
  always_ff @(posedge clock)
    if (reset) offset_q <= '0;
    else offset_q <= offset_d;
endmodule

// File: rtl/lane_renderer.sv
// lane_renderer: draws scrolling traffic lanes and the frog, and reports frog/object overlap per frame
module lane_renderer
  import lane_renderer_pkg::*;
#(
  parameter int N_LANES  = 8,
  parameter int LANE_H   = 32,
  parameter int LANE_Y0  = 112,
  parameter int PER_LOG2 = 7,
  parameter int OBJ_LEN  = 48,
  parameter int FROG_SZ  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [9:0]           next_x,
  input  logic [9:0]           next_y,
  input  logic                 enable,
  input  logic [3*N_LANES-1:0] lane_speed,
  input  logic [N_LANES-1:0]   lane_dir,
  input  logic [9:0]           frog_x,
  input  logic [9:0]           frog_y,
  output logic [7:0]           color_out,
  output logic                 frame_tick,
  output logic                 hit
);
  logic [N_LANES-1:0] in_lane, lane_obj, lane_odd;
  logic [7:0] color_q, color_d;
  logic sticky_q, sticky_d, hit_q, hit_d, frog, obj, off;
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    lane_scroller #(
      .PER_LOG2(PER_LOG2),
      .OBJ_LEN (OBJ_LEN),
      .Y_LO    (LANE_Y0 + i * LANE_H),
      .Y_HI    (LANE_Y0 + (i + 1) * LANE_H)
    ) u_lane (
      .clock  (clock),
      .reset  (reset),
      .step   (frame_tick & enable),
      .speed  (lane_speed[3*i +: 3]),
      .dir    (lane_dir[i]),
      .next_x (next_x),
      .next_y (next_y),
      .in_lane(in_lane[i]),
      .is_obj (lane_obj[i])
    );
    assign lane_odd[i] = (i % 2 == 1) ? in_lane[i] : 1'b0;
  end
  // pixel classification, colour priority and per-frame overlap bookkeeping
  always_comb begin
    frame_tick = next_x == '0 && next_y == V_ACTIVE;
    off  = next_x >= H_ACTIVE || next_y >= V_ACTIVE;
    frog = 32'(next_x) >= 32'(frog_x) && 32'(next_x) < 32'(frog_x) + FROG_SZ &&
           32'(next_y) >= 32'(frog_y) && 32'(next_y) < 32'(frog_y) + FROG_SZ;
    obj  = |lane_obj;
    color_d  = off ? C_BLANK : frog ? C_FROG : obj ? C_OBJ :
               |lane_odd ? C_LANE_ODD : |in_lane ? C_LANE_EVEN : C_GRASS;
    sticky_d = frame_tick ? 1'b0 : sticky_q | (frog & obj);
    hit_d    = frame_tick ? sticky_q : hit_q;
  end
  // registered pixel colour and overlap flags
  always_ff @(posedge clock)
    if (reset) begin
      color_q  <= '0;
      sticky_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      color_q  <= color_d;
      sticky_q <= sticky_d;
      hit_q    <= hit_d;
    end
  assign color_out = color_q;
  assign hit       = hit_q;
endmodule
